pipeline_mul_param: RTL and testbench

- Parametrised successor of the single-register fetch/decode/execute/retire pipeline with a shift-add multiplier.
- Adds the following over that block:
  - NREG-entry register file with per-instruction register select
  - parametrised data, immediate and memory widths
  - writable instruction memory
  - SUB operation
  - synchronous reset
  - a constant-time multiply mode
- Serves as the leakage-verification benchmark where timing of MUL is either data-dependent or fixed, selected by parameter.

---
 rtl/pipeline_mul_pkg.sv | 25 ++
 rtl/shift_add_mul.sv | 74 +++++++
 rtl/pipeline_mul_param.sv | 151 +++++++++++++++
 tb/tb_pipeline_mul_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mul_pkg.sv
// Shared opcodes, instruction field positions and the per-stage tag
// carried from fetch to retire by pipeline_mul_param.
package pipeline_mul_pkg;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h02;
  localparam logic [7:0] OP_CLR = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;

  localparam int OP_LSB   = 0;
  localparam int OP_W     = 8;
  localparam int RSEL_LSB = 8;
  localparam int IMM_LSB  = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] counter;
  } stage_tag_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_CLR) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per busy cycle, either
// stopping once the multiplier runs out of set bits or always running IMM_W rounds.
module shift_add_mul #(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 16,
  parameter int MUL_CT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [IMM_W-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(IMM_W + 1);

  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [IMM_W-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [XLEN-1:0]  acc_sum;
  logic             last_round;

  always_comb begin
    acc_sum = acc_q + (a_q & {XLEN{b_q[0]}});
    // Constant-time mode ignores the operand value so the round count never leaks it.
    if (MUL_CT != 0) last_round = (cnt_q == CNT_W'(IMM_W - 1));
    else             last_round = (b_q <= IMM_W'(1));

    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_sum;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_round) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = busy_q && last_round;
  assign result = acc_sum;

endmodule

// File: rtl/pipeline_mul_param.sv
// Fetch / decode / execute / writeback pipeline over an NREG register file with
// forwarding from writeback and a stalling shift-add multiplier in execute.
module pipeline_mul_param
  import pipeline_mul_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 4,
  parameter int IMM_W      = 16,
  parameter int IMEM_DEPTH = 32,
  parameter int MUL_CT     = 0,
  localparam int RSEL_W    = $clog2(NREG),
  localparam int IA_W      = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_we,
  input  logic [IA_W-1:0]   imem_waddr,
  input  logic [31:0]       imem_wdata,
  input  logic [RSEL_W-1:0] dbg_rsel,
  output logic [XLEN-1:0]   dbg_rdata,
  output logic              busy,
  output logic              retire_valid,
  output logic [31:0]       retire_pc,
  output logic [31:0]       retire_instr,
  output logic [31:0]       retire_counter
);

  logic [31:0]       imem_mem [IMEM_DEPTH];
  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];

  logic [31:0]       pc_q, pc_d, counter_q, counter_d;
  logic              dec_valid_q, dec_valid_d;
  stage_tag_t        dec_tag_q, dec_tag_d;
  logic              wb_we_q, wb_we_d;
  logic [RSEL_W-1:0] wb_rsel_q, wb_rsel_d;
  logic [XLEN-1:0]   wb_res_q, wb_res_d;
  stage_tag_t        wb_tag_q, wb_tag_d;
  logic              retire_valid_q, retire_valid_d;
  stage_tag_t        retire_tag_q, retire_tag_d;

  logic [31:0]       fetch_instr;
  logic [OP_W-1:0]   dec_op;
  logic [RSEL_W-1:0] dec_rsel;
  logic [XLEN-1:0]   dec_imm, src;
  logic              exec_fire, mul_start, mul_busy, mul_done;
  logic [XLEN-1:0]   mul_result;

  // Write-only port; the combinational read below sees the old word this cycle.
  always_ff @(posedge clk) begin
    if (imem_we) imem_mem[imem_waddr] <= imem_wdata;
  end

  assign fetch_instr = imem_mem[pc_q[IA_W-1:0]];
  assign dec_op      = dec_tag_q.instr[OP_LSB +: OP_W];
  assign dec_rsel    = dec_tag_q.instr[RSEL_LSB +: RSEL_W];
  assign dec_imm     = XLEN'(dec_tag_q.instr[IMM_LSB +: IMM_W]);
  assign src         = (wb_we_q && (wb_rsel_q == dec_rsel)) ? wb_res_q : regs_q[dec_rsel];
  assign exec_fire   = !mul_busy && dec_valid_q && is_legal_op(dec_op);
  assign mul_start   = exec_fire && (dec_op == OP_MUL);

  shift_add_mul #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W),
    .MUL_CT(MUL_CT)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (src),
    .b     (dec_tag_q.instr[IMM_LSB +: IMM_W]),
    .busy  (mul_busy),
    .done  (mul_done),
    .result(mul_result)
  );

  always_comb begin
    pc_d        = pc_q;
    counter_d   = counter_q;
    dec_valid_d = dec_valid_q;
    dec_tag_d   = dec_tag_q;
    if (!mul_busy) begin
      pc_d        = pc_q + 32'd1;
      counter_d   = counter_q + 32'd1;
      dec_valid_d = 1'b1;
      dec_tag_d   = '{pc: pc_q, instr: fetch_instr, counter: counter_q};
    end

    // A starting MUL parks its rsel/tag in the writeback stage with wb_we low
    // until the multiplier reports done.
    wb_we_d   = 1'b0;
    wb_rsel_d = wb_rsel_q;
    wb_res_d  = wb_res_q;
    wb_tag_d  = wb_tag_q;
    if (mul_done) begin
      wb_we_d  = 1'b1;
      wb_res_d = mul_result;
    end else if (exec_fire) begin
      wb_rsel_d = dec_rsel;
      wb_tag_d  = dec_tag_q;
      case (dec_op)
        OP_ADD: begin wb_res_d = src + dec_imm; wb_we_d = 1'b1; end
        OP_SUB: begin wb_res_d = src - dec_imm; wb_we_d = 1'b1; end
        OP_CLR: begin wb_res_d = '0;            wb_we_d = 1'b1; end
        default: ;
      endcase
    end

    regs_d = regs_q;
    if (wb_we_q) regs_d[wb_rsel_q] = wb_res_q;

    retire_valid_d = wb_we_q;
    retire_tag_d   = wb_we_q ? wb_tag_q : retire_tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= '0;
      counter_q      <= '0;
      dec_valid_q    <= 1'b0;
      dec_tag_q      <= '0;
      wb_we_q        <= 1'b0;
      wb_rsel_q      <= '0;
      wb_res_q       <= '0;
      wb_tag_q       <= '0;
      retire_valid_q <= 1'b0;
      retire_tag_q   <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      pc_q           <= pc_d;
      counter_q      <= counter_d;
      dec_valid_q    <= dec_valid_d;
      dec_tag_q      <= dec_tag_d;
      wb_we_q        <= wb_we_d;
      wb_rsel_q      <= wb_rsel_d;
      wb_res_q       <= wb_res_d;
      wb_tag_q       <= wb_tag_d;
      retire_valid_q <= retire_valid_d;
      retire_tag_q   <= retire_tag_d;
      regs_q         <= regs_d;
    end
  end

  assign dbg_rdata      = regs_q[dbg_rsel];
  assign busy           = mul_busy;
  assign retire_valid   = retire_valid_q;
  assign retire_pc      = retire_tag_q.pc;
  assign retire_instr   = retire_tag_q.instr;
  assign retire_counter = retire_tag_q.counter;

endmodule

// File: tb/tb_pipeline_mul_param.sv
// Runs a data-dependent and a constant-time instance side by side on the same
// programs; a program-order reference model feeds per-instance scoreboards.
module tb_pipeline_mul_param;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] counter;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_we = 1'b0;
  logic [4:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic        dbg_force = 1'b0;
  logic [1:0]  dbg_force_sel = '0;

  logic [1:0]  dbg_rsel_w [2];
  logic [31:0] dbg_rdata_w [2];
  logic        busy_w [2];
  logic        retire_valid_w [2];
  logic [31:0] retire_pc_w [2];
  logic [31:0] retire_instr_w [2];
  logic [31:0] retire_counter_w [2];

  exp_t exp_q [2][$];
  int   busy_exp_q [2][$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  // cyc is 0 during the first cycle after reset is released.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign dbg_rsel_w[gi] = dbg_force ? dbg_force_sel : retire_instr_w[gi][9:8];

    pipeline_mul_param #(.MUL_CT(gi)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .imem_we       (imem_we),
      .imem_waddr    (imem_waddr),
      .imem_wdata    (imem_wdata),
      .dbg_rsel      (dbg_rsel_w[gi]),
      .dbg_rdata     (dbg_rdata_w[gi]),
      .busy          (busy_w[gi]),
      .retire_valid  (retire_valid_w[gi]),
      .retire_pc     (retire_pc_w[gi]),
      .retire_instr  (retire_instr_w[gi]),
      .retire_counter(retire_counter_w[gi])
    );

    int   run = 0;
    exp_t e;

    always @(negedge clk) begin
      if (rst) begin
        run = 0;
      end else begin
        if (busy_w[gi]) begin
          run++;
        end else if (run != 0) begin
          if (busy_exp_q[gi].size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL ct%0d_busy_unexpected: busy run of %0d cycles, none expected", gi, run);
          end else begin
            chk($sformatf("ct%0d_busy_len", gi), run, busy_exp_q[gi].pop_front());
          end
          run = 0;
        end
        if (retire_valid_w[gi]) begin
          if (exp_q[gi].size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL ct%0d_retire_unexpected: pc %0h retired, none expected", gi, retire_pc_w[gi]);
          end else begin
            e = exp_q[gi].pop_front();
            $display("ct%0d retire pc=%0d instr=%08h cnt=%0d val=%0h cyc=%0d",
                     gi, retire_pc_w[gi], retire_instr_w[gi], retire_counter_w[gi], dbg_rdata_w[gi], cyc);
            chk($sformatf("ct%0d_pc", gi), retire_pc_w[gi], e.pc);
            chk($sformatf("ct%0d_instr", gi), retire_instr_w[gi], e.instr);
            chk($sformatf("ct%0d_counter", gi), retire_counter_w[gi], e.counter);
            chk($sformatf("ct%0d_reg_val", gi), dbg_rdata_w[gi], e.val);
            chk($sformatf("ct%0d_retire_cycle", gi), cyc, e.cyc);
          end
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [1:0] rs, input logic [15:0] imm);
    return {imm, 6'b0, rs, op};
  endfunction

  // Program-order reference: architectural results plus the documented latencies
  // (execute one cycle after fetch, MUL busy for its round count, retire two later).
  task automatic push_expected(input int d, input logic [31:0] prog [32], input int ncyc);
    logic [31:0] r [4];
    logic [31:0] instr;
    logic [15:0] imm;
    logic [1:0]  rs;
    int ex = 1;
    int n_prev = 0;
    int n, bl;
    logic legal;
    exp_t e;
    for (int k = 0; k < 4; k++) r[k] = '0;
    for (int i = 0; i < 2000; i++) begin
      if (i > 0) ex = ex + 1 + n_prev;
      if (ex >= ncyc) break;
      instr = prog[i % 32];
      imm   = instr[31:16];
      rs    = instr[9:8];
      n     = 0;
      legal = 1'b1;
      case (instr[7:0])
        8'h01: r[rs] = r[rs] + {16'h0, imm};
        8'h04: r[rs] = r[rs] - {16'h0, imm};
        8'h03: r[rs] = '0;
        8'h02: begin
          bl = 0;
          for (int b = 0; b < 16; b++) if (imm[b]) bl = b + 1;
          n = (d != 0) ? 16 : ((bl < 1) ? 1 : bl);
          r[rs] = r[rs] * {16'h0, imm};
        end
        default: legal = 1'b0;
      endcase
      if (n != 0 && ex + 1 + n < ncyc) busy_exp_q[d].push_back(n);
      if (legal && ex + 2 + n < ncyc) begin
        e.pc = i; e.instr = instr; e.counter = i; e.val = r[rs]; e.cyc = ex + 2 + n;
        exp_q[d].push_back(e);
      end
      n_prev = n;
    end
  endtask

  // Loads imem under reset, runs ncyc cycles, then re-asserts reset.
  task automatic run_phase(input logic [31:0] prog [32], input int ncyc, input bit abort_chk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      imem_we = 1'b1; imem_waddr = 5'(i); imem_wdata = prog[i];
      @(posedge clk); #1;
    end
    imem_we = 1'b0;
    for (int d = 0; d < 2; d++) push_expected(d, prog, ncyc);
    rst = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    if (abort_chk) for (int d = 0; d < 2; d++) chk($sformatf("ct%0d_busy_before_abort", d), busy_w[d], 1'b1);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ct%0d_retire_drain", d), exp_q[d].size(), 0);
      chk($sformatf("ct%0d_busy_drain", d), busy_exp_q[d].size(), 0);
      exp_q[d].delete();
      busy_exp_q[d].delete();
    end
    if (abort_chk) begin
      @(posedge clk); #1;
      dbg_force = 1'b1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ct%0d_abort_busy", d), busy_w[d], 1'b0);
        chk($sformatf("ct%0d_abort_retire_valid", d), retire_valid_w[d], 1'b0);
        chk($sformatf("ct%0d_abort_retire_pc", d), retire_pc_w[d], 32'h0);
      end
      for (int k = 0; k < 4; k++) begin
        dbg_force_sel = 2'(k); #1;
        for (int d = 0; d < 2; d++) chk($sformatf("ct%0d_abort_reg%0d", d, k), dbg_rdata_w[d], 32'h0);
      end
      dbg_force = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] prog [32];
    int sel;

    repeat (2) @(posedge clk);
    #1;
    dbg_force = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ct%0d_rst_busy", d), busy_w[d], 1'b0);
      chk($sformatf("ct%0d_rst_retire_valid", d), retire_valid_w[d], 1'b0);
      chk($sformatf("ct%0d_rst_retire_pc", d), retire_pc_w[d], 32'h0);
      chk($sformatf("ct%0d_rst_retire_instr", d), retire_instr_w[d], 32'h0);
      chk($sformatf("ct%0d_rst_retire_counter", d), retire_counter_w[d], 32'h0);
      chk($sformatf("ct%0d_rst_reg0", d), dbg_rdata_w[d], 32'h0);
    end
    dbg_force = 1'b0;

    // Directed program; 60 cycles wraps the fetch index past IMEM_DEPTH for MUL_CT=0.
    for (int i = 0; i < 32; i++) prog[i] = 32'h0;
    prog[0]  = mk(8'h01, 2'd0, 16'd5);
    prog[1]  = mk(8'h01, 2'd0, 16'd7);
    prog[2]  = mk(8'h04, 2'd0, 16'd2);
    prog[3]  = mk(8'h01, 2'd1, 16'd3);
    prog[4]  = mk(8'h02, 2'd1, 16'h0005);
    prog[5]  = mk(8'h01, 2'd1, 16'd1);
    prog[6]  = mk(8'h02, 2'd3, 16'h0000);
    prog[7]  = mk(8'h01, 2'd2, 16'd9);
    prog[8]  = mk(8'h01, 2'd3, 16'd1);
    prog[9]  = mk(8'h03, 2'd2, 16'd0);
    prog[10] = mk(8'h7F, 2'd0, 16'd0);
    prog[11] = mk(8'h01, 2'd0, 16'd1);
    run_phase(prog, 60, 1'b0);

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 32; i++) begin
        sel = $urandom_range(0, 6);
        prog[i] = $urandom;
        case (sel)
          0: prog[i][7:0] = 8'h01;
          1: prog[i][7:0] = 8'h04;
          2: prog[i][7:0] = 8'h03;
          3: begin prog[i][7:0] = 8'h02; prog[i][31:16] = 16'($urandom_range(0, 255)); end
          4: prog[i][7:0] = 8'h02;
          5: prog[i][7:0] = 8'h01;
          default: if (prog[i][7:0] inside {8'h01, 8'h02, 8'h03, 8'h04}) prog[i][7:0] = 8'h7F;
        endcase
      end
      run_phase(prog, 150, 1'b0);
    end

    // Reset in the middle of a long multiply, then rerun to show fetch restarts at 0.
    for (int i = 0; i < 32; i++) prog[i] = 32'h0;
    prog[0] = mk(8'h01, 2'd1, 16'd3);
    prog[1] = mk(8'h02, 2'd1, 16'hFFFF);
    prog[2] = mk(8'h01, 2'd1, 16'd1);
    run_phase(prog, 9, 1'b1);
    run_phase(prog, 40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
